scene_recover: RTL and testbench
================================

// Module: scene_recover
// PURPOSE
//  Scene-radiance recovery stage; sits directly downstream of the transmission estimator.
//  Pairs each buffered hazy RGB pixel with the estimator's 11-bit one_by_t sample.
//  Per channel, computes J = (I - A) * one_by_t / 2^FRAC_BITS + A, saturated to 8 bits.
//  A small pixel FIFO absorbs the estimator's pipeline latency, so the two streams need not be time-aligned.
// PARAMETERS
//  FRAC_BITS    8     fractional bits of one_by_t; 256 represents 1.0
//  DEPTH        8     pixel FIFO depth in entries; must be a power of 2, >= 4
//  ONE_BY_T_MAX 1024  clamp ceiling applied to one_by_t (limits gain, i.e. enforces minimum t)
// PORTS
//  i_clk        in   1   clock; all logic is on the rising edge
//  i_rst        in   1   synchronous, active-high reset
//  i_pix_valid  in   1   hazy pixel present on i_r/i_g/i_b
//  i_r,i_g,i_b  in   8   hazy pixel channels
//  o_pix_ready  out  1   FIFO can accept a pixel; a push occurs when i_pix_valid && o_pix_ready
//  i_t_valid    in   1   one_by_t sample present; no backpressure on this stream
//  one_by_t     in   11  unsigned reciprocal transmission (U3.FRAC_BITS)
//  Arloc,Agloc,Abloc in 8  atmospheric light per channel; sampled on each pop
//  o_valid      out  1   recovered pixel valid; single-cycle pulse per pair
//  o_r,o_g,o_b  out  8   recovered pixel channels
//  o_underflow  out  1   sticky: set when a one_by_t sample arrived with the FIFO empty
//  o_count      out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO pointers and count = 0; o_valid = 0; o_r/o_g/o_b = 0; o_underflow = 0; pipeline valids = 0.
//   Reset wins over every other event in the same cycle. Reset mid-operation discards all in-flight data.
//  o_pix_ready = (o_count != DEPTH), combinational from the count register.
//  Pop occurs when i_t_valid is high and count != 0, using the registered count (no bypass).
//   Consequence: a pixel pushed in the same cycle a t sample arrives on an empty FIFO is not paired;
//   that t sample is dropped and o_underflow is set.
//  Simultaneous push and pop: count unchanged. Both pointers wrap modulo DEPTH.
//  i_t_valid with count == 0: sample dropped, no o_valid, o_underflow <= 1 (cleared only by reset).
//  Pipeline (pop cycle = C):
//   S1 @C+1: tc = min(one_by_t, ONE_BY_T_MAX); d_x = {1'b0,I_x} - {1'b0,A_x} (9-bit signed); latch A_x.
//   S2 @C+2: p_x = d_x * tc, computed in 21-bit signed arithmetic (tc zero-extended).
//   S3 @C+3: s_x = (p_x >>> FRAC_BITS) + A_x (arithmetic shift, floor);
//            o_x = 0 if s_x < 0, 255 if s_x > 255, else s_x[7:0]; o_valid = 1.
//  Latency: o_valid is asserted exactly 3 cycles after a popping i_t_valid; throughput is 1 pair per cycle.
//  No output backpressure; between pulses o_r/o_g/o_b hold their last value.
//  The FIFO preserves arrival order: the k-th popped pixel pairs with the k-th accepted t sample.
// TESTING
//  Identity: push I=(100,150,200), A=(200,200,200), one_by_t=256 -> 3 cycles later o=(100,150,200).
//  Gain and clamp: I=100, A=200, one_by_t=512 -> 0; I=250, A=100, t=1024 -> 255;
//   I=10, A=200, t=512 -> 0; I=150, A=100, t=2047 (clamped to 1024) -> 255.
//  Fill FIFO: push 8 pixels with no t -> o_pix_ready=0, o_count=8; then 8 t pulses back-to-back ->
//   8 consecutive o_valid pulses in push order; o_count returns to 0.
//  Underflow: i_t_valid with an empty FIFO -> no o_valid, o_underflow=1 and it stays 1;
//   later pushes still pair normally.
//  Simultaneous push and pop at count=4 for 20 cycles -> count stays 4, outputs in order, pointers wrap.
//  Reset asserted with 5 entries queued and 2 in the pipeline -> next cycle o_count=0, o_valid=0,
//   and no stale outputs afterwards.

Source files
------------

// File: rtl/scene_recover.sv
// Scene-radiance recovery: a small pixel FIFO pairs hazy RGB pixels with one_by_t
// samples, then a 3-stage pipeline computes J = (I - A) * one_by_t / 2^FRAC_BITS + A.
module scene_recover #(
  parameter int FRAC_BITS    = 8,
  parameter int DEPTH        = 8,
  parameter int ONE_BY_T_MAX = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pix_valid,
  input  logic [7:0]               i_r,
  input  logic [7:0]               i_g,
  input  logic [7:0]               i_b,
  output logic                     o_pix_ready,
  input  logic                     i_t_valid,
  input  logic [10:0]              one_by_t,
  input  logic [7:0]               Arloc,
  input  logic [7:0]               Agloc,
  input  logic [7:0]               Abloc,
  output logic                     o_valid,
  output logic [7:0]               o_r,
  output logic [7:0]               o_g,
  output logic [7:0]               o_b,
  output logic                     o_underflow,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_CNT  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [10:0]   TC_MAX   = ONE_BY_T_MAX[10:0];

  function automatic logic signed [8:0] diff9(input logic [7:0] i, input logic [7:0] a);
    diff9 = $signed({1'b0, i}) - $signed({1'b0, a});
  endfunction

  function automatic logic signed [20:0] mul21(input logic signed [8:0] d, input logic [10:0] tc);
    logic signed [20:0] de;
    logic signed [20:0] te;
    de = {{12{d[8]}}, d};
    te = {10'd0, tc};
    mul21 = de * te;
  endfunction

  // Shift is an arithmetic floor; result clamps to the 8-bit pixel range.
  function automatic logic [7:0] sat8(input logic signed [20:0] p, input logic [7:0] a);
    logic signed [20:0] s;
    s = (p >>> FRAC_BITS) + $signed({13'd0, a});
    if (s < 21'sd0) begin
      sat8 = 8'd0;
    end else if (s > 21'sd255) begin
      sat8 = 8'd255;
    end else begin
      sat8 = s[7:0];
    end
  endfunction

  logic [23:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic               push_s, pop_s;
  logic               underflow_q;
  logic [7:0]         pix_s [3];
  logic [7:0]         amb_s [3];
  logic [10:0]        tc_s;

  logic               s1_valid_q;
  logic [10:0]        s1_tc_q;
  logic signed [8:0]  s1_d_q [3];
  logic [7:0]         s1_a_q [3];
  logic               s2_valid_q;
  logic signed [20:0] s2_p_q [3];
  logic [7:0]         s2_a_q [3];
  logic               out_valid_q;
  logic [7:0]         out_q [3];

  // Pop decision uses the registered count only, so a same-cycle push cannot be paired.
  assign o_pix_ready = (count_q != FULL_CNT);
  assign push_s      = i_pix_valid && o_pix_ready;
  assign pop_s       = i_t_valid && (count_q != ZERO_CNT);
  assign pix_s[0]    = mem_q[rd_ptr_q][23:16];
  assign pix_s[1]    = mem_q[rd_ptr_q][15:8];
  assign pix_s[2]    = mem_q[rd_ptr_q][7:0];
  assign amb_s[0]    = Arloc;
  assign amb_s[1]    = Agloc;
  assign amb_s[2]    = Abloc;
  assign tc_s        = (one_by_t > TC_MAX) ? TC_MAX : one_by_t;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Pixel storage; stale contents are harmless because pointers reset.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {i_r, i_g, i_b};
    end
  end

  // FIFO pointers, count and sticky underflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= ZERO_CNT;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (i_t_valid && (count_q == ZERO_CNT)) underflow_q <= 1'b1;
    end
  end

  // Three-stage recovery pipeline: difference/clamp, multiply, shift/offset/saturate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_tc_q     <= 11'd0;
      for (int c = 0; c < 3; c++) begin
        s1_d_q[c] <= 9'sd0;
        s1_a_q[c] <= 8'd0;
        s2_p_q[c] <= 21'sd0;
        s2_a_q[c] <= 8'd0;
        out_q[c]  <= 8'd0;
      end
    end else begin
      s1_valid_q  <= pop_s;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (pop_s) s1_tc_q <= tc_s;
      for (int c = 0; c < 3; c++) begin
        if (pop_s) begin
          s1_d_q[c] <= diff9(pix_s[c], amb_s[c]);
          s1_a_q[c] <= amb_s[c];
        end
        if (s1_valid_q) begin
          s2_p_q[c] <= mul21(s1_d_q[c], s1_tc_q);
          s2_a_q[c] <= s1_a_q[c];
        end
        if (s2_valid_q) out_q[c] <= sat8(s2_p_q[c], s2_a_q[c]);
      end
    end
  end

  assign o_valid     = out_valid_q;
  assign o_r         = out_q[0];
  assign o_g         = out_q[1];
  assign o_b         = out_q[2];
  assign o_underflow = underflow_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_scene_recover.sv
// Self-checking bench for scene_recover: directed spec cases plus randomized traffic
// compared against a queue-based reference model.
module tb_scene_recover;

  localparam int DEPTH = 8;
  localparam int TMAX  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0, t_valid = 1'b0;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic [7:0]  ar = 8'd0, ag = 8'd0, ab = 8'd0;
  logic [10:0] obt = 11'd0;
  logic        pix_ready, o_valid, o_underflow;
  logic [7:0]  o_r, o_g, o_b;
  logic [3:0]  o_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [23:0] mq[$];
  logic [55:0] exp_q[$];
  logic [55:0] obs_q[$];
  logic        m_under = 1'b0;

  scene_recover #(.FRAC_BITS(8), .DEPTH(DEPTH), .ONE_BY_T_MAX(TMAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid),
    .i_r(r), .i_g(g), .i_b(b), .o_pix_ready(pix_ready),
    .i_t_valid(t_valid), .one_by_t(obt),
    .Arloc(ar), .Agloc(ag), .Abloc(ab),
    .o_valid(o_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_underflow(o_underflow), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Reference: J = floor((I - A) * min(t, TMAX) / 256) + A, clamped to [0,255].
  function automatic logic [7:0] recover(input int i, input int a, input int t);
    int tc, p, q, s;
    tc = (t > TMAX) ? TMAX : t;
    p  = (i - a) * tc;
    q  = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    s = q + a;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  task automatic cyc_step(input logic pv, input logic [7:0] pr, input logic [7:0] pg,
                          input logic [7:0] pb, input logic tv, input logic [10:0] t,
                          input logic [7:0] a_r, input logic [7:0] a_g, input logic [7:0] a_b);
    int sz;
    logic [23:0] px;
    pix_valid = pv; r = pr; g = pg; b = pb;
    t_valid = tv; obt = t; ar = a_r; ag = a_g; ab = a_b;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_under = 1'b0;
      while (exp_q.size() > 0 && int'(exp_q[$][55:24]) >= cyc) void'(exp_q.pop_back());
    end else begin
      sz = mq.size();
      if (tv && sz == 0) m_under = 1'b1;
      if (tv && sz != 0) begin
        px = mq.pop_front();
        exp_q.push_back({32'(cyc + 2),
                         recover(int'(px[23:16]), int'(a_r), int'(t)),
                         recover(int'(px[15:8]),  int'(a_g), int'(t)),
                         recover(int'(px[7:0]),   int'(a_b), int'(t))});
      end
      if (pv && sz != DEPTH) mq.push_back({pr, pg, pb});
    end
    #1;
    if (o_valid) obs_q.push_back({32'(cyc), o_r, o_g, o_b});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    tests_run++;
    if ({o_valid, o_r, o_g, o_b, o_underflow, o_count, pix_ready} !== {1'b0, 24'd0, 1'b0, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b rgb=%h uf=%b cnt=%0d rdy=%b, expected 0/000000/0/0/1",
               o_valid, {o_r, o_g, o_b}, o_underflow, o_count, pix_ready);
    end
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_identity;
    logic [2:0] seen;
    cyc_step(1'b1, 8'd100, 8'd150, 8'd200, 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'd256, 8'd200, 8'd200, 8'd200);
    seen[0] = o_valid;
    idle(1);
    seen[1] = o_valid;
    idle(1);
    seen[2] = o_valid;
    tests_run++;
    if (seen !== 3'b100) begin
      tests_failed++;
      $display("FAIL identity_latency: got valid pattern %b, expected 100", seen);
    end
    tests_run++;
    if ({o_r, o_g, o_b} !== {8'd100, 8'd150, 8'd200}) begin
      tests_failed++;
      $display("FAIL identity_value: got %0d,%0d,%0d expected 100,150,200", o_r, o_g, o_b);
    end
    idle(1);
    tests_run++;
    if (o_valid !== 1'b0 || {o_r, o_g, o_b} !== {8'd100, 8'd150, 8'd200}) begin
      tests_failed++;
      $display("FAIL identity_hold: got v=%b rgb=%h expected v=0 rgb=6496c8", o_valid, {o_r, o_g, o_b});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gain_clamp;
    logic [23:0] pix [5];
    logic [23:0] amb [5];
    logic [10:0] tv [5];
    logic [23:0] want [5];
    pix[0] = {8'd100, 8'd10, 8'd150};  amb[0] = {8'd200, 8'd200, 8'd100}; tv[0] = 11'd512;
    pix[1] = {8'd250, 8'd250, 8'd250}; amb[1] = {8'd100, 8'd100, 8'd100}; tv[1] = 11'd1024;
    pix[2] = {8'd150, 8'd150, 8'd150}; amb[2] = {8'd100, 8'd100, 8'd100}; tv[2] = 11'd2047;
    pix[3] = {8'd101, 8'd99, 8'd100};  amb[3] = {8'd100, 8'd100, 8'd100}; tv[3] = 11'd2047;
    pix[4] = {8'd7, 8'd8, 8'd9};       amb[4] = {8'd50, 8'd60, 8'd70};    tv[4] = 11'd0;
    want[0] = {8'd0, 8'd0, 8'd200};
    want[1] = {8'd255, 8'd255, 8'd255};
    want[2] = {8'd255, 8'd255, 8'd255};
    want[3] = {8'd104, 8'd96, 8'd100};
    want[4] = {8'd50, 8'd60, 8'd70};
    for (int k = 0; k < 5; k++)
      cyc_step(1'b1, pix[k][23:16], pix[k][15:8], pix[k][7:0], 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 5; k++)
      cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, tv[k], amb[k][23:16], amb[k][15:8], amb[k][7:0]);
    idle(3);
    tests_run++;
    if (obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL gain_count: got %0d outputs expected 5", obs_q.size());
    end
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k][23:0] !== want[k] || int'(obs_q[k][55:24]) != int'(obs_q[0][55:24]) + k) begin
        tests_failed++;
        $display("FAIL gain_clamp[%0d]: got rgb=%h cyc=%0d expected rgb=%h cyc=%0d", k,
                 obs_q[k][23:0], obs_q[k][55:24], want[k], int'(obs_q[0][55:24]) + k);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_fill;
    for (int k = 0; k < DEPTH; k++)
      cyc_step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    tests_run++;
    if (o_count !== 4'd8 || pix_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b expected 8/0", o_count, pix_ready);
    end
    cyc_step(1'b1, 8'd1, 8'd2, 8'd3, 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    tests_run++;
    if (o_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL fill_overpush: got cnt=%0d expected 8", o_count);
    end
    for (int k = 0; k < DEPTH; k++)
      cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'($urandom_range(0, 1300)),
               8'($urandom), 8'($urandom), 8'($urandom));
    idle(3);
    tests_run++;
    if (o_count !== 4'd0 || pix_ready !== 1'b1 || obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL fill_drain: got cnt=%0d rdy=%b outs=%0d expected 0/1/%0d",
               o_count, pix_ready, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL fill_order[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_underflow;
    cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'd256, 8'd10, 8'd10, 8'd10);
    idle(4);
    tests_run++;
    if (obs_q.size() != 0 || o_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_flag: got outs=%0d uf=%b expected 0/1", obs_q.size(), o_underflow);
    end
    cyc_step(1'b1, 8'd40, 8'd50, 8'd60, 1'b1, 11'd300, 8'd20, 8'd20, 8'd20);
    tests_run++;
    if (o_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL underflow_samecycle: got cnt=%0d expected 1", o_count);
    end
    cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'd384, 8'd30, 8'd90, 8'd200);
    idle(4);
    tests_run++;
    if (o_underflow !== 1'b1 || obs_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL underflow_sticky: got uf=%b outs=%0d expected 1/1", o_underflow, obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL underflow_pair: got %h expected %h", obs_q[0], exp_q[0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_simul;
    for (int k = 0; k < 4; k++)
      cyc_step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      cyc_step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 11'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));
      tests_run++;
      if (o_count !== 4'd4) begin
        tests_failed++;
        $display("FAIL simul_count[%0d]: got %0d expected 4", k, o_count);
      end
    end
    for (int k = 0; k < 4; k++)
      cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    idle(3);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL simul_outs: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL simul_order[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [10:0] t;
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       t = 11'($urandom_range(0, 255));
        1:       t = 11'($urandom_range(256, 1024));
        2:       t = 11'($urandom_range(1025, 2047));
        default: t = 11'($urandom);
      endcase
      cyc_step($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 9) < 4, t, 8'($urandom), 8'($urandom), 8'($urandom));
      tests_run++;
      if (o_count !== 4'(mq.size()) || pix_ready !== (mq.size() != DEPTH) || o_underflow !== m_under) begin
        tests_failed++;
        errs++;
        if (errs < 10)
          $display("FAIL random_state[%0d]: got cnt=%0d rdy=%b uf=%b expected %0d/%b/%b",
                   k, o_count, pix_ready, o_underflow, mq.size(), mq.size() != DEPTH, m_under);
      end
    end
    for (int k = 0; k < DEPTH && mq.size() > 0; k++)
      cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    idle(3);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_outs: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL random_pair[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midop;
    for (int k = 0; k < 7; k++)
      cyc_step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 2; k++)
      cyc_step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 11'd256, 8'd5, 8'd5, 8'd5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    tests_run++;
    if (o_count !== 4'd0 || o_valid !== 1'b0 || o_underflow !== 1'b0 || pix_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_midop: got cnt=%0d v=%b uf=%b rdy=%b expected 0/0/0/1",
               o_count, o_valid, o_underflow, pix_ready);
    end
    idle(6);
    tests_run++;
    if (obs_q.size() != 0 || exp_q.size() != 0 || {o_r, o_g, o_b} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_stale: got outs=%0d rgb=%h expected 0 outputs rgb=000000",
               obs_q.size(), {o_r, o_g, o_b});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_identity;
    test_gain_clamp;
    test_fill;
    test_underflow;
    test_simul;
    test_random;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
